// File: rtl/seletor_funcionalidade_n_if.sv
// Channel bus for seletor_funcionalidade_n: per-channel enables, requests and data in,
// selected data, grant vector, winning index and error flag out.
interface seletor_funcionalidade_n_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   P;
    logic [N-1:0]   V;
    logic [N*W-1:0] D;
    logic [1:0]     M;
    logic           CLR;
    logic [W-1:0]   S;
    logic           S_VALID;
    logic [N-1:0]   GNT;
    logic [IW-1:0]  IDX;
    logic           ERR;

    modport master (output P, V, D, M, CLR, input S, S_VALID, GNT, IDX, ERR);
    modport slave  (input P, V, D, M, CLR, output S, S_VALID, GNT, IDX, ERR);
endinterface

// File: rtl/seletor_funcionalidade_n.sv
// Registered N-channel selector: OR-merge, fixed priority, round-robin with grant hold, force zero.
// Optional sticky request-on-disabled-channel flag enabled by SELETOR_FUNCIONALIDADE_ERR_EN.
module seletor_funcionalidade_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    seletor_funcionalidade_n_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    localparam logic [1:0] MODE_OR   = 2'b00;
    localparam logic [1:0] MODE_PRI  = 2'b01;
    localparam logic [1:0] MODE_RR   = 2'b10;
    localparam logic [1:0] MODE_ZERO = 2'b11;

    logic [W-1:0]  s_q, s_d;
    logic          s_valid_q, s_valid_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    m_q;

    logic [N-1:0]  elig;
    logic [CW-1:0] cnt_eff;
    logic [W-1:0]  or_data;
    logic          hi_found, rr_found, hold_ok;
    int            hi_idx, rr_idx, win;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        elig     = bus.P & bus.V;
        cnt_eff  = (bus.M != m_q) ? '0 : cnt_q;
        hi_found = 1'b0;
        hi_idx   = 0;
        or_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                hi_found = 1'b1;
                hi_idx   = i;
                or_data  = or_data | bus.D[i*W +: W];
            end
        end

        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found && elig[(int'(ptr_q) + k) % N]) begin
                rr_found = 1'b1;
                rr_idx   = (int'(ptr_q) + k) % N;
            end
        end

        // A zero count means nobody currently holds a tenure, so the pointer channel must re-arbitrate.
        hold_ok = (cnt_eff != '0) && (cnt_eff < HOLD_C) && elig[ptr_q];

        s_d       = '0;
        s_valid_d = 1'b0;
        gnt_d     = '0;
        idx_d     = idx_q;
        cnt_d     = cnt_eff;
        ptr_d     = ptr_q;
        win       = 0;

        case (bus.M)
            MODE_OR: begin
                s_d       = or_data;
                gnt_d     = elig;
                s_valid_d = hi_found;
                idx_d     = IW'(hi_idx);
            end
            MODE_PRI: begin
                if (hi_found) begin
                    s_d           = bus.D[hi_idx*W +: W];
                    gnt_d[hi_idx] = 1'b1;
                    idx_d         = IW'(hi_idx);
                    s_valid_d     = 1'b1;
                end
            end
            MODE_RR: begin
                if (hold_ok) begin
                    win   = int'(ptr_q);
                    cnt_d = cnt_eff + CW'(1);
                end else if (rr_found) begin
                    win   = rr_idx;
                    ptr_d = IW'(rr_idx);
                    cnt_d = CW'(1);
                end else begin
                    cnt_d = '0;
                end
                if (hold_ok || rr_found) begin
                    s_d        = bus.D[win*W +: W];
                    gnt_d[win] = 1'b1;
                    idx_d      = IW'(win);
                    s_valid_d  = 1'b1;
                end
            end
            MODE_ZERO: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            s_valid_q <= 1'b0;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= IW'(N - 1);
            cnt_q     <= '0;
            m_q       <= MODE_OR;
        end else begin
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            m_q       <= bus.M;
        end
    end

    assign bus.S       = s_q;
    assign bus.S_VALID = s_valid_q;
    assign bus.GNT     = gnt_q;
    assign bus.IDX     = idx_q;

`ifdef SELETOR_FUNCIONALIDADE_ERR_EN
    logic err_q;

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (|(bus.V & ~bus.P)) | (err_q & ~bus.CLR);
        end
    end

    assign bus.ERR = err_q;
`else
    assign bus.ERR = 1'b0;
`endif
endmodule

// File: tb/tb_seletor_funcionalidade_n.sv
// Randomised self-checking bench for seletor_funcionalidade_n against a behavioural model,
// plus a second N=2, W=1 instance exercising the legacy two-input behaviour.
module tb_seletor_funcionalidade_n;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 4;
    localparam int IW   = 2;
    localparam int VW   = W + 1 + N + IW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int tests_run    = 0;
    int tests_failed = 0;

    seletor_funcionalidade_n_if #(.N(N), .W(W)) bus ();
    seletor_funcionalidade_n_if #(.N(2), .W(1)) lg ();

    seletor_funcionalidade_n #(.N(N), .W(W), .HOLD(HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    seletor_funcionalidade_n #(.N(2), .W(1), .HOLD(HOLD)) dut_legacy (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (lg)
    );

    always #5 clk = ~clk;

    // Behavioural model state: expected outputs plus round-robin owner and tenure length.
    logic [W-1:0]  e_s;
    logic          e_valid;
    logic [N-1:0]  e_gnt;
    logic [IW-1:0] e_idx;
    logic          e_err;
    int            owner;
    int            run;
    logic [1:0]    last_mode;

    function automatic logic [VW-1:0] exp_vec();
        return {e_s, e_valid, e_gnt, e_idx, e_err};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.S, bus.S_VALID, bus.GNT, bus.IDX, bus.ERR};
    endfunction

    function automatic logic [N*W-1:0] rand_d();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        e_s = '0; e_valid = 1'b0; e_gnt = '0; e_idx = '0; e_err = 1'b0;
        owner = N - 1; run = 0; last_mode = 2'b00;
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] v,
                              input logic [N*W-1:0] d, input logic [1:0] m, input logic clr);
        logic [N-1:0] e;
        int hi;
        int q[$];
        e  = p & v;
        hi = -1;
        for (int i = 0; i < N; i++) if (e[i]) hi = i;
        if (m != last_mode) run = 0;
        e_s = '0; e_valid = 1'b0; e_gnt = '0;
        case (m)
            2'b00: begin
                for (int i = 0; i < N; i++) if (e[i]) e_s = e_s | d[i*W +: W];
                e_gnt   = e;
                e_valid = (e != '0);
                e_idx   = (hi < 0) ? '0 : IW'(hi);
            end
            2'b01: begin
                if (hi >= 0) begin
                    e_s = d[hi*W +: W]; e_gnt[hi] = 1'b1; e_idx = IW'(hi); e_valid = 1'b1;
                end
            end
            2'b10: begin
                if (e == '0) begin
                    run = 0;
                end else begin
                    if (run > 0 && run < HOLD && e[owner]) begin
                        run++;
                    end else begin
                        // Candidates in circular order after the current owner.
                        for (int k = 1; k <= N; k++) q.push_back((owner + k) % N);
                        while (!e[q[0]]) void'(q.pop_front());
                        owner = q[0];
                        run   = 1;
                    end
                    e_s = d[owner*W +: W]; e_gnt[owner] = 1'b1; e_idx = IW'(owner); e_valid = 1'b1;
                end
            end
            default: run = 0;
        endcase
`ifdef SELETOR_FUNCIONALIDADE_ERR_EN
        e_err = (|(v & ~p)) || (e_err && !clr);
`else
        e_err = 1'b0;
`endif
        last_mode = m;
    endtask

    task automatic drive(input logic [N-1:0] p, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input logic [1:0] m, input logic clr);
        bus.P = p; bus.V = v; bus.D = d; bus.M = m; bus.CLR = clr;
        model_step(p, v, d, m, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (act_vec() !== '0) begin
            tests_failed++;
            $display("FAIL %s main outputs during reset: got %h expected 0", name, act_vec());
        end
        tests_run++;
        if ({lg.S, lg.S_VALID, lg.GNT, lg.IDX, lg.ERR} !== 6'b0) begin
            tests_failed++;
            $display("FAIL %s legacy outputs during reset: got %b expected 0", name,
                     {lg.S, lg.S_VALID, lg.GNT, lg.IDX, lg.ERR});
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.P = '0; bus.V = '0; bus.D = '0; bus.M = 2'b00; bus.CLR = 1'b0;
        lg.P = '0; lg.V = '0; lg.D = '0; lg.M = 2'b00; lg.CLR = 1'b0;
        apply_reset("reset");
    endtask

    task automatic test_legacy();
        logic [1:0] p, v, d, e;
        logic [4:0] exp5, act5;
        for (int i = 0; i < 22; i++) begin
            if (i == 0)      begin p = 2'b10; v = 2'b11; d = 2'b10; end
            else if (i == 1) begin p = 2'b00; v = 2'b11; d = 2'b10; end
            else             begin p = 2'($urandom); v = 2'($urandom); d = 2'($urandom); end
            lg.P = p; lg.V = v; lg.D = d; lg.M = 2'b00; lg.CLR = 1'b0;
            @(posedge clk);
            #1;
            e    = p & v;
            exp5 = {|(e & d), |e, e, e[1]};
            if (i == 0) exp5 = 5'b1_1_10_1;
            if (i == 1) exp5 = 5'b0_0_00_0;
            act5 = {lg.S, lg.S_VALID, lg.GNT, lg.IDX};
            tests_run++;
            if (act5 !== exp5) begin
                tests_failed++;
                $display("FAIL legacy cycle %0d: got {S,V,GNT,IDX}=%b expected %b", i, act5, exp5);
            end
        end
    endtask

    task automatic test_or_merge();
        logic [N*W-1:0] d;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                d = {8'hAA, 8'hF0, 8'hFF, 8'h0F};
                drive(4'b0101, 4'hF, d, 2'b00, 1'b0);
                tests_run++;
                if ({bus.S, bus.S_VALID, bus.GNT, bus.IDX} !== {8'hFF, 1'b1, 4'b0101, 2'd2}) begin
                    tests_failed++;
                    $display("FAIL or_merge directed: got S=%h GNT=%b IDX=%0d expected S=ff GNT=0101 IDX=2",
                             bus.S, bus.GNT, bus.IDX);
                end
            end else begin
                drive(N'($urandom), N'($urandom), rand_d(), 2'b00, 1'b0);
            end
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL or_merge cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        logic [N*W-1:0] d;
        logic [N-1:0] vtab [3] = '{4'b0110, 4'b0010, 4'b0000};
        logic [W+IW:0] etab [3] = '{{8'h22, 1'b1, 2'd2}, {8'h11, 1'b1, 2'd1}, {8'h00, 1'b0, 2'd1}};
        d = {8'h44, 8'h22, 8'h11, 8'h33};
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, vtab[i], d, 2'b01, 1'b0);
            tests_run++;
            if ({bus.S, bus.S_VALID, bus.IDX} !== etab[i]) begin
                tests_failed++;
                $display("FAIL priority directed step %0d: got {S,V,IDX}=%h expected %h", i,
                         {bus.S, bus.S_VALID, bus.IDX}, etab[i]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            drive(N'($urandom), N'($urandom), rand_d(), 2'b01, 1'b0);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL priority cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] gtab [18] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8,
                                    4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h8};
        apply_reset("rr_reset");
        for (int i = 0; i < 18; i++) begin
            drive(4'b1011, (i == 17) ? 4'b1001 : 4'b1011, rand_d(), 2'b10, 1'b0);
            tests_run++;
            if (bus.GNT !== gtab[i]) begin
                tests_failed++;
                $display("FAIL rr_hold cycle %0d: got GNT=%b expected %b", i, bus.GNT, gtab[i]);
            end
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL rr_hold model cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 60; i++) begin
            drive(N'($urandom) | 4'b0011, N'($urandom), rand_d(), 2'b10, 1'b0);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL rr_random cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] mtab [17];
        for (int i = 0; i < 17; i++) mtab[i] = (i == 10) ? 2'b11 : 2'b10;
        for (int i = 0; i < 17; i++) begin
            drive(4'b0100, 4'b0100, rand_d(), mtab[i], 1'b0);
            tests_run++;
            if ({bus.S_VALID, bus.GNT} !== ((i == 10) ? 5'b0_0000 : 5'b1_0100)) begin
                tests_failed++;
                $display("FAIL mode_switch cycle %0d: got {S_VALID,GNT}=%b", i, {bus.S_VALID, bus.GNT});
            end
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL mode_switch model cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_err();
        logic [N-1:0] vtab [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic ctab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef SELETOR_FUNCIONALIDADE_ERR_EN
        logic etab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        logic etab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, vtab[i], rand_d(), 2'b00, ctab[i]);
            tests_run++;
            if (bus.ERR !== etab[i]) begin
                tests_failed++;
                $display("FAIL err step %0d: got ERR=%b expected %b", i, bus.ERR, etab[i]);
            end
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 300; i++) begin
            drive(N'($urandom), N'($urandom), rand_d(), 2'($urandom), ($urandom_range(0, 7) == 0));
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_mix cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midrun_reset();
        lg.P = 2'b10; lg.V = 2'b11; lg.D = 2'b10; lg.M = 2'b00; lg.CLR = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'hF, 4'hF, rand_d(), 2'b10, 1'b0);
        apply_reset("midrun_reset");
        drive(4'b1010, 4'b1010, rand_d(), 2'b10, 1'b0);
        tests_run++;
        if (bus.GNT !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midrun_reset first grant: got GNT=%b expected 0010", bus.GNT);
        end
        tests_run++;
        if (act_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL midrun_reset model: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_legacy();
        test_or_merge();
        test_priority();
        test_round_robin();
        test_mode_switch();
        test_err();
        test_random_mix();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
